// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: instruction field positions, fetch FSM encoding, defaults.
// No logic, so no latency or backpressure of its own.
package mips_pkg;

  localparam int OP_HI     = 31;
  localparam int OP_LO     = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Next-PC target computation and priority mux (Jr > J/Jal > taken branch > pc+4).
// Purely combinational; no backpressure.
module next_pc_sel (
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        J,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        jr_misalign
);

  logic        br_taken;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign br_taken    = (Beq & zero) | (Bne & ~zero);
  assign br_offset   = {{14{imm[15]}}, imm, 2'b00};
  assign br_target   = pc_plus4 + br_offset;
  assign j_target    = {pc_plus4[31:28], target, 2'b00};
  // Low bits are dropped so the PC stays word-aligned; the caller records the fault.
  assign jr_target   = {rs_data[31:2], 2'b00};
  assign jr_misalign = Jr & (|rs_data[1:0]);

  always_comb begin
    next_pc = pc_plus4;
    if (Jr)
      next_pc = jr_target;
    else if (J || Jal)
      next_pc = j_target;
    else if (br_taken)
      next_pc = br_target;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, RUN/HALT FSM, retired counter and sticky Jr-misalign flag.
// PC updates one cycle after decode inputs; stall holds all state for that cycle.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             Beq,
  input  logic             Bne,
  input  logic             J,
  input  logic             Jal,
  input  logic             Jr,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      imm,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     state, state_nxt;
  logic [31:0]      pc_q, pc_nxt, sel_pc;
  logic [CNT_W-1:0] retired_q, retired_nxt;
  logic             misalign_q, misalign_nxt;
  logic             jr_misalign;

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign halted    = (state == HALT);
  assign misalign  = misalign_q;
  assign retired   = retired_q;

  assign op    = imem_data[OP_HI:OP_LO];
  assign rs    = imem_data[RS_HI:RS_LO];
  assign rt    = imem_data[RT_HI:RT_LO];
  assign rd    = imem_data[RD_HI:RD_LO];
  assign shamt = imem_data[SHAMT_HI:SHAMT_LO];
  assign funct = imem_data[FUNCT_HI:FUNCT_LO];
  assign imm   = imem_data[IMM_HI:IMM_LO];

  next_pc_sel u_next_pc_sel (
    .pc_plus4    (pc_plus4),
    .imm         (imem_data[IMM_HI:IMM_LO]),
    .target      (imem_data[TARGET_HI:TARGET_LO]),
    .Beq         (Beq),
    .Bne         (Bne),
    .J           (J),
    .Jal         (Jal),
    .Jr          (Jr),
    .zero        (zero),
    .rs_data     (rs_data),
    .next_pc     (sel_pc),
    .jr_misalign (jr_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      retired_q  <= retired_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  // The halt word itself neither retires nor redirects the PC.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    retired_nxt  = retired_q;
    misalign_nxt = misalign_q;
    if (state == RUN && !stall) begin
      if (imem_data == HALT_WORD) begin
        state_nxt = HALT;
      end else begin
        pc_nxt      = sel_pc;
        retired_nxt = retired_q + CNT_ONE;
        if (jr_misalign)
          misalign_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus queues the expected post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] imem_addr, imem_data, rs_data, pc, pc_plus4;
  logic        Beq, Bne, J, Jal, Jr, zero;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        halted, misalign;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        halted;
    logic        misalign;
    logic [31:0] retired;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  fetch_pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .Beq       (Beq),
    .Bne       (Bne),
    .J         (J),
    .Jal       (Jal),
    .Jr        (Jr),
    .zero      (zero),
    .rs_data   (rs_data),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .op        (op),
    .funct     (funct),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .halted    (halted),
    .misalign  (misalign),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s got=%h exp=%h", tag, what, got, exp);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check(mon_e.tag, "pc", pc, mon_e.pc);
      check(mon_e.tag, "imem_addr", imem_addr, mon_e.pc);
      check(mon_e.tag, "halted", {31'd0, halted}, {31'd0, mon_e.halted});
      check(mon_e.tag, "misalign", {31'd0, misalign}, {31'd0, mon_e.misalign});
      check(mon_e.tag, "retired", retired, mon_e.retired);
    end
  end

  task automatic tick(input string tag, input logic [31:0] e_pc, input logic e_h,
                      input logic e_m, input logic [31:0] e_r);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.halted = e_h; e.misalign = e_m; e.retired = e_r;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; imem_data = 32'h0; rs_data = 32'h0;
    Beq = 1'b0; Bne = 1'b0; J = 1'b0; Jal = 1'b0; Jr = 1'b0; zero = 1'b0;
  endtask

  task automatic jr_to(input string tag, input logic [31:0] tgt, input logic e_m, input logic [31:0] e_r);
    idle_inputs();
    Jr = 1'b1; rs_data = tgt;
    tick(tag, tgt, 1'b0, e_m, e_r);
    Jr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick("reset", 32'h0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;

    for (int i = 1; i <= 4; i++)
      tick("nop_run", 32'(4 * i), 1'b0, 1'b0, 32'(i));

    // beq with imm=-4 taken from 0x10
    imem_data = 32'h1000_FFFC; Beq = 1'b1; zero = 1'b1;
    #1;
    check("fields", "op", {26'd0, op}, 32'h4);
    check("fields", "imm", {16'd0, imm}, 32'hFFFC);
    check("fields", "rd", {27'd0, rd}, 32'h1F);
    tick("beq_taken", 32'h04, 1'b0, 1'b0, 32'd5);
    idle_inputs();
    tick("nop_a", 32'h08, 1'b0, 1'b0, 32'd6);
    tick("nop_b", 32'h0C, 1'b0, 1'b0, 32'd7);
    tick("nop_c", 32'h10, 1'b0, 1'b0, 32'd8);
    imem_data = 32'h1000_FFFC; Beq = 1'b1; zero = 1'b0;
    tick("beq_not_taken", 32'h14, 1'b0, 1'b0, 32'd9);

    jr_to("jr_aligned", 32'h1000_0020, 1'b0, 32'd10);
    imem_data = 32'h0800_0040; J = 1'b1;
    tick("j_region", 32'h1000_0100, 1'b0, 1'b0, 32'd11);
    jr_to("jr_back", 32'h1000_0020, 1'b0, 32'd12);
    imem_data = 32'h0800_0040; J = 1'b1; Jr = 1'b1; rs_data = 32'h0000_0203;
    tick("jr_beats_j", 32'h0000_0200, 1'b0, 1'b1, 32'd13);
    idle_inputs();
    imem_data = 32'h0C00_0100; Jal = 1'b1;
    #1;
    check("jal_link", "pc_plus4", pc_plus4, 32'h0000_0204);
    tick("jal", 32'h0000_0400, 1'b0, 1'b1, 32'd14);
    idle_inputs();
    imem_data = 32'h1400_0003; Bne = 1'b1; zero = 1'b0;
    tick("bne_taken", 32'h0000_0410, 1'b0, 1'b1, 32'd15);
    imem_data = 32'h1000_0001; Beq = 1'b1; Bne = 1'b1; zero = 1'b0;
    tick("beq_bne_both", 32'h0000_0418, 1'b0, 1'b1, 32'd16);

    idle_inputs();
    imem_data = 32'h1000_0002; Beq = 1'b1; zero = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++)
      tick("stall_hold", 32'h0000_0418, 1'b0, 1'b1, 32'd16);
    stall = 1'b0;
    tick("stall_release", 32'h0000_0424, 1'b0, 1'b1, 32'd17);

    jr_to("jr_to_40", 32'h0000_0040, 1'b1, 32'd18);
    imem_data = 32'hFFFF_FFFF;
    tick("halt_enter", 32'h0000_0040, 1'b1, 1'b1, 32'd18);
    imem_data = 32'h0800_0040; J = 1'b1;
    tick("halt_ignore_j", 32'h0000_0040, 1'b1, 1'b1, 32'd18);
    stall = 1'b1; Jr = 1'b1; rs_data = 32'h0000_0100;
    tick("halt_ignore_jr", 32'h0000_0040, 1'b1, 1'b1, 32'd18);
    stall = 1'b0; reset = 1'b1;
    tick("reset_from_halt", 32'h0, 1'b0, 1'b0, 32'd0);

    jr_to("jr_top", 32'hFFFF_FFFC, 1'b0, 32'd1);
    idle_inputs();
    tick("pc_wrap", 32'h0000_0000, 1'b0, 1'b0, 32'd2);

    stall = 1'b1; Jr = 1'b1; rs_data = 32'h0000_0003;
    tick("stall_misalign_hold", 32'h0, 1'b0, 1'b0, 32'd2);
    stall = 1'b0;
    tick("jr_misaligned", 32'h0, 1'b0, 1'b1, 32'd3);
    idle_inputs();
    tick("misalign_sticky", 32'h4, 1'b0, 1'b1, 32'd4);

    @(posedge clk);
    #3;
    check("drain", "sb_left", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch stage directly upstream of the single-cycle MIPS control decoder. It holds the PC and drives the instruction-memory address. It splits the fetched word into op/funct/register/immediate fields for the control unit and datapath. It consumes the decoder's Beq, Bne, J, Jal and Jr outputs, plus the ALU zero flag, to select the next PC. It also provides a stall input, a sticky HALT state and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold PC, state and counter this cycle.
imem_addr  out  32  byte address to instruction memory; equals pc.
imem_data  in  32  instruction word; combinational read of imem_addr.
Beq  in  1  from control unit.
Bne  in  1  from control unit.
J  in  1  from control unit.
Jal  in  1  from control unit.
Jr  in  1  from control unit.
zero  in  1  ALU zero flag for the current instruction.
rs_data  in  32  register-file rs read value; jump-register target.
pc  out  32  current PC.
pc_plus4  out  32  pc + 4; link value written to $31 on jal.
op  out  6  imem_data[31:26].
funct  out  6  imem_data[5:0].
rs  out  5  imem_data[25:21].
rt  out  5  imem_data[20:16].
rd  out  5  imem_data[15:11].
shamt  out  5  imem_data[10:6].
imm  out  16  imem_data[15:0].
halted  out  1  high while in HALT state.
misalign  out  1  sticky flag: a Jr target had nonzero bits [1:0].
retired  out  CNT_W  count of instructions completed since reset.

Behaviour:
- Reset (synchronous): pc=RESET_PC, state=RUN, halted=0, misalign=0, retired=0. Field outputs follow imem_data combinationally at all times.
- FSM has two states, RUN and HALT.
  - RUN -> HALT at an edge where imem_data==HALT_WORD and stall=0.
  - HALT -> RUN only through reset.
- In HALT: pc and retired are frozen, and halted=1. Beq/Bne/J/Jal/Jr/stall are ignored.
- In RUN with stall=1: pc, retired and misalign all hold. No other state changes.
- In RUN with stall=0 and a non-halt instruction, pc advances and retired increments by 1 (wraps at 2^CNT_W). Next-PC priority, highest first:
  1. Jr: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, misalign is set and stays set until reset.
  2. J or Jal: {pc_plus4[31:28], imem_data[25:0], 2'b00}.
  3. Branch taken, i.e. (Beq & zero) | (Bne & ~zero): pc_plus4 + (sign-extended imm << 2), modulo 2^32.
  4. Otherwise pc_plus4.
- The halt instruction itself is not counted in retired. Its control-flow inputs are ignored.
- All PC arithmetic is 32-bit with wrap: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
- Simultaneous select signals resolve by the priority above. Beq and Bne together resolve through the zero-flag expression.
- Reset has priority over stall, halt and branches in the same cycle. Reset mid-stall or in HALT returns to the reset state at that edge.
- Latency: PC update takes effect the next cycle. imem_addr reflects the new pc immediately after the edge.

Decomposition:
- Shared package mips_pkg holds:
  - field positions (OP_HI/LO, RS, RT, RD, SHAMT, FUNCT, IMM, TARGET);
  - HALT_WORD default;
  - state encoding: RUN=1'b0, HALT=1'b1;
  - RESET_PC default.
- One natural sub-module, next_pc_sel: purely combinational target computation and priority mux. The PC register, FSM, counter and misalign flag stay in the top.

Test Plan:
- Reset then 4 free-running cycles, stall=0, NOP words (32'h0) -> pc sequence 0,4,8,C,10; retired=4; halted=0.
- At pc=0x10, imem_data=beq with imm=16'hFFFC, Beq=1, zero=1 -> next pc=0x04. Repeat with zero=0 -> next pc=0x14.
- J with target 26'h0000040 at pc=0x1000_0020 -> next pc=0x1000_0100. In the same cycle with Jr=1, rs_data=0x0000_0203 -> Jr wins: pc=0x0000_0200, misalign=1 and stays 1.
- stall=1 for 3 cycles with Beq=1, zero=1 -> pc, retired unchanged. Release stall -> branch taken once.
- imem_data=HALT_WORD at pc=0x40 -> halted=1 next cycle, pc stays 0x40, retired unchanged while J=1 is driven. Assert reset -> pc=0, halted=0, retired=0.
- Preload pc=0xFFFF_FFFC with a NOP -> next pc=0x0000_0000.
